// File: rtl/wb_sba_arbiter.sv
// Two-master pipelined Wishbone arbiter: core data master (m0) and debug SBA master (m1)
// share a single slave port, with bus lock, outstanding tracking and an ack watchdog.
module wb_sba_arbiter #(
  parameter int unsigned AW          = 32,
  parameter int unsigned DW          = 32,
  parameter bit          ROUND_ROBIN = 1'b1,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  input  logic              m0_we_i,
  input  logic [AW-1:0]     m0_adr_i,
  input  logic [DW/8-1:0]   m0_sel_i,
  input  logic [DW-1:0]     m0_dat_i,
  output logic [DW-1:0]     m0_dat_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  output logic              m0_stall_o,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  input  logic              m1_we_i,
  input  logic [AW-1:0]     m1_adr_i,
  input  logic [DW/8-1:0]   m1_sel_i,
  input  logic [DW-1:0]     m1_dat_i,
  output logic [DW-1:0]     m1_dat_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic              m1_stall_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  output logic              s_we_o,
  output logic [AW-1:0]     s_adr_o,
  output logic [DW/8-1:0]   s_sel_o,
  output logic [DW-1:0]     s_dat_o,
  input  logic [DW-1:0]     s_dat_i,
  input  logic              s_ack_i,
  input  logic              s_err_i,
  input  logic              s_stall_i,
  output logic [1:0]        gnt_o,
  output logic              timeout_o
);

  localparam int unsigned WDW     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam int unsigned TO_M1   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [3:0]  OUT_MAX = 4'd15;

  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} state_t;

  state_t          state_q, state_d;
  logic            last_q, last_d;
  logic [3:0]      out_q, out_d;
  logic [WDW-1:0]  wd_q, wd_d;
  logic            to_q, to_d;
  logic            to_m_q, to_m_d;

  logic            granted, sel1, busy, full, accept, resp, fire;
  logic            g_cyc, g_stb, g_we;
  logic [AW-1:0]   g_adr;
  logic [DW/8-1:0] g_sel;
  logic [DW-1:0]   g_dat;

  assign granted = (state_q != IDLE);
  assign sel1    = (state_q == GNT1);
  assign busy    = (out_q != 4'd0);
  assign full    = (out_q == OUT_MAX);

  // Request path: granted master's fields, zeroed when idle
  assign g_cyc   = sel1 ? m1_cyc_i : m0_cyc_i;
  assign g_stb   = sel1 ? m1_stb_i : m0_stb_i;
  assign g_we    = sel1 ? m1_we_i  : m0_we_i;
  assign g_adr   = sel1 ? m1_adr_i : m0_adr_i;
  assign g_sel   = sel1 ? m1_sel_i : m0_sel_i;
  assign g_dat   = sel1 ? m1_dat_i : m0_dat_i;

  assign s_cyc_o = granted & g_cyc;
  assign s_stb_o = granted & g_cyc & g_stb & ~full;
  assign s_we_o  = granted & g_we;
  assign s_adr_o = granted ? g_adr : '0;
  assign s_sel_o = granted ? g_sel : '0;
  assign s_dat_o = granted ? g_dat : '0;

  assign accept  = s_stb_o & ~s_stall_i;
  // Responses with nothing outstanding are stray and dropped
  assign resp    = busy & (s_ack_i | s_err_i);
  assign fire    = (TIMEOUT != 0) && busy && !resp && (wd_q == WDW'(TO_M1));

  // Response path: watchdog error is delivered the cycle after the fire decision
  assign m0_ack_o   = (state_q == GNT0) & busy & s_ack_i;
  assign m0_err_o   = ((state_q == GNT0) & busy & s_err_i) | (to_q & ~to_m_q);
  assign m0_stall_o = (state_q != GNT0) | s_stall_i | full;
  assign m1_ack_o   = sel1 & busy & s_ack_i;
  assign m1_err_o   = (sel1 & busy & s_err_i) | (to_q & to_m_q);
  assign m1_stall_o = ~sel1 | s_stall_i | full;
  assign m0_dat_o   = s_dat_i;
  assign m1_dat_o   = s_dat_i;

  assign gnt_o      = {sel1, state_q == GNT0};
  assign timeout_o  = to_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      out_q   <= '0;
      wd_q    <= '0;
      to_q    <= 1'b0;
      to_m_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      out_q   <= out_d;
      wd_q    <= wd_d;
      to_q    <= to_d;
      to_m_q  <= to_m_d;
    end
  end

  // Arbitration, lock/handover, outstanding and watchdog bookkeeping
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    out_d   = out_q;
    wd_d    = wd_q;
    to_d    = 1'b0;
    to_m_d  = to_m_q;

    case (state_q)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || !ROUND_ROBIN || last_q)) state_d = GNT0;
        else if (m1_cyc_i)                                     state_d = GNT1;
      end
      GNT0: begin
        if (fire)           state_d = IDLE;
        else if (!m0_cyc_i) state_d = m1_cyc_i ? GNT1 : IDLE;
      end
      GNT1: begin
        if (fire)           state_d = IDLE;
        else if (!m1_cyc_i) state_d = m0_cyc_i ? GNT0 : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept && !resp)      out_d = out_q + 4'd1;
    else if (resp && !accept) out_d = out_q - 4'd1;

    if (!busy || resp) wd_d = '0;
    else               wd_d = wd_q + WDW'(1);

    // Any grant change abandons the old master's outstanding requests
    if (state_d != state_q) begin
      wd_d = '0;
      if (granted) out_d = '0;
      if (state_d == GNT0)      last_d = 1'b0;
      else if (state_d == GNT1) last_d = 1'b1;
    end

    if (fire) begin
      to_d   = 1'b1;
      to_m_d = sel1;
    end
  end

endmodule

// File: tb/tb_wb_sba_arbiter.sv
// Directed bench for wb_sba_arbiter: instance a is round-robin with the default watchdog,
// instance b is fixed-priority with an 8-cycle watchdog; both share all inputs.
module tb_wb_sba_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we;
  logic [AW-1:0] m0_adr, m1_adr;
  logic [SW-1:0] m0_sel, m1_sel;
  logic [DW-1:0] m0_dat, m1_dat;
  logic [DW-1:0] s_dat;
  logic          s_ack, s_err, s_stall;

  logic [DW-1:0] m0_dat_a, m1_dat_a, s_dat_a, m0_dat_b, m1_dat_b, s_dat_b;
  logic          m0_ack_a, m0_err_a, m0_stall_a, m1_ack_a, m1_err_a, m1_stall_a;
  logic          m0_ack_b, m0_err_b, m0_stall_b, m1_ack_b, m1_err_b, m1_stall_b;
  logic          s_cyc_a, s_stb_a, s_we_a, s_cyc_b, s_stb_b, s_we_b;
  logic [AW-1:0] s_adr_a, s_adr_b;
  logic [SW-1:0] s_sel_a, s_sel_b;
  logic [1:0]    gnt_a, gnt_b;
  logic          timeout_a, timeout_b;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  wb_sba_arbiter #(.AW(AW), .DW(DW), .ROUND_ROBIN(1'b1), .TIMEOUT(255)) dut_a (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_a), .m0_ack_o(m0_ack_a),
    .m0_err_o(m0_err_a), .m0_stall_o(m0_stall_a),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_a), .m1_ack_o(m1_ack_a),
    .m1_err_o(m1_err_a), .m1_stall_o(m1_stall_a),
    .s_cyc_o(s_cyc_a), .s_stb_o(s_stb_a), .s_we_o(s_we_a), .s_adr_o(s_adr_a),
    .s_sel_o(s_sel_a), .s_dat_o(s_dat_a), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_stall_i(s_stall), .gnt_o(gnt_a), .timeout_o(timeout_a)
  );

  wb_sba_arbiter #(.AW(AW), .DW(DW), .ROUND_ROBIN(1'b0), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_b), .m0_ack_o(m0_ack_b),
    .m0_err_o(m0_err_b), .m0_stall_o(m0_stall_b),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_b), .m1_ack_o(m1_ack_b),
    .m1_err_o(m1_err_b), .m1_stall_o(m1_stall_b),
    .s_cyc_o(s_cyc_b), .s_stb_o(s_stb_b), .s_we_o(s_we_b), .s_adr_o(s_adr_b),
    .s_sel_o(s_sel_b), .s_dat_o(s_dat_b), .s_dat_i(s_dat), .s_ack_i(s_ack),
    .s_err_i(s_err), .s_stall_i(s_stall), .gnt_o(gnt_b), .timeout_o(timeout_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    m0_cyc = 1'b0; m0_stb = 1'b0; m0_we = 1'b0; m0_adr = '0; m0_sel = '0; m0_dat = '0;
    m1_cyc = 1'b0; m1_stb = 1'b0; m1_we = 1'b0; m1_adr = '0; m1_sel = '0; m1_dat = '0;
    s_dat = '0; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h3000; s_ack = 1'b1;
    step();
    checks++; if (gnt_a !== 2'b00) $display("FAIL rst_gnt_a: got %b want 00", gnt_a); else passed++;
    checks++; if (gnt_b !== 2'b00) $display("FAIL rst_gnt_b: got %b want 00", gnt_b); else passed++;
    checks++; if (s_cyc_a !== 1'b0) $display("FAIL rst_s_cyc: got %b want 0", s_cyc_a); else passed++;
    checks++; if (s_stb_a !== 1'b0) $display("FAIL rst_s_stb: got %b want 0", s_stb_a); else passed++;
    checks++; if (s_we_a !== 1'b0) $display("FAIL rst_s_we: got %b want 0", s_we_a); else passed++;
    checks++; if (s_adr_a !== 32'h0) $display("FAIL rst_s_adr: got %h want 0", s_adr_a); else passed++;
    checks++; if (m0_stall_a !== 1'b1) $display("FAIL rst_m0_stall: got %b want 1", m0_stall_a); else passed++;
    checks++; if (m1_stall_a !== 1'b1) $display("FAIL rst_m1_stall: got %b want 1", m1_stall_a); else passed++;
    checks++; if (m0_ack_a !== 1'b0) $display("FAIL rst_m0_ack: got %b want 0", m0_ack_a); else passed++;
    checks++; if (timeout_a !== 1'b0) $display("FAIL rst_timeout: got %b want 0", timeout_a); else passed++;
    clear_inputs();
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_write();
    int acks;
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1;
    m0_adr = 32'h3000; m0_sel = 4'hF; m0_dat = 32'h1234_5678;
    #1;
    checks++; if (s_cyc_a !== 1'b0) $display("FAIL sw_cyc_t: got %b want 0", s_cyc_a); else passed++;
    step();
    checks++; if (s_cyc_a !== 1'b1) $display("FAIL sw_cyc_t1: got %b want 1", s_cyc_a); else passed++;
    checks++; if (gnt_a !== 2'b01) $display("FAIL sw_gnt: got %b want 01", gnt_a); else passed++;
    checks++; if (s_adr_a !== 32'h3000) $display("FAIL sw_adr: got %h want 3000", s_adr_a); else passed++;
    checks++; if (s_dat_a !== 32'h1234_5678) $display("FAIL sw_dat: got %h want 12345678", s_dat_a); else passed++;
    checks++; if (s_we_a !== 1'b1) $display("FAIL sw_we: got %b want 1", s_we_a); else passed++;
    checks++; if (m0_stall_a !== 1'b0) $display("FAIL sw_m0_stall: got %b want 0", m0_stall_a); else passed++;
    checks++; if (m1_stall_a !== 1'b1) $display("FAIL sw_m1_stall: got %b want 1", m1_stall_a); else passed++;
    step();
    m0_stb = 1'b0;
    acks = 0;
    // ack two cycles after acceptance, then a stray ack with nothing outstanding
    for (int i = 0; i < 4; i++) begin
      s_ack = (i == 1) || (i == 3);
      #1;
      if (m0_ack_a === 1'b1) acks++;
      step();
    end
    s_ack = 1'b0;
    checks++; if (acks !== 1) $display("FAIL sw_ack_count: got %0d want 1", acks); else passed++;
    m0_cyc = 1'b0;
    #1;
    checks++; if (gnt_a !== 2'b01) $display("FAIL sw_gnt_hold: got %b want 01", gnt_a); else passed++;
    step();
    checks++; if (gnt_a !== 2'b00) $display("FAIL sw_gnt_idle: got %b want 00", gnt_a); else passed++;
    checks++; if (s_cyc_a !== 1'b0) $display("FAIL sw_cyc_idle: got %b want 0", s_cyc_a); else passed++;
  endtask

  task automatic test_contention();
    logic [1:0] exp_a;
    apply_reset();
    for (int r = 0; r < 3; r++) begin
      exp_a = (r == 1) ? 2'b10 : 2'b01;
      m0_cyc = 1'b1; m1_cyc = 1'b1;
      step();
      checks++; if (gnt_a !== exp_a) $display("FAIL rr_gnt%0d: got %b want %b", r, gnt_a, exp_a); else passed++;
      checks++; if (gnt_b !== 2'b01) $display("FAIL fp_gnt%0d: got %b want 01", r, gnt_b); else passed++;
      m0_cyc = 1'b0; m1_cyc = 1'b0;
      step();
      step();
    end
  endtask

  task automatic test_lock_handover();
    apply_reset();
    m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b0; m1_adr = 32'h3000; m1_sel = 4'hF;
    step();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h4000; m0_sel = 4'hF;
    for (int i = 0; i < 4; i++) begin
      m1_adr = 32'h3000 + 32'(4 * i);
      #1;
      checks++; if (gnt_a !== 2'b10) $display("FAIL lk_gnt%0d: got %b want 10", i, gnt_a); else passed++;
      checks++; if (s_adr_a !== m1_adr) $display("FAIL lk_adr%0d: got %h want %h", i, s_adr_a, m1_adr); else passed++;
      checks++; if (m0_stall_a !== 1'b1) $display("FAIL lk_m0_stall%0d: got %b want 1", i, m0_stall_a); else passed++;
      step();
    end
    m1_stb = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_ack = 1'b1;
      s_dat = 32'hA000_0000 + 32'(i);
      #1;
      checks++; if (m1_ack_a !== 1'b1) $display("FAIL lk_m1_ack%0d: got %b want 1", i, m1_ack_a); else passed++;
      checks++; if (m1_dat_a !== s_dat) $display("FAIL lk_m1_dat%0d: got %h want %h", i, m1_dat_a, s_dat); else passed++;
      checks++; if (m0_ack_a !== 1'b0) $display("FAIL lk_m0_ack%0d: got %b want 0", i, m0_ack_a); else passed++;
      checks++; if (m0_stall_a !== 1'b1) $display("FAIL lk_m0_stall_r%0d: got %b want 1", i, m0_stall_a); else passed++;
      step();
    end
    s_ack = 1'b0;
    m1_cyc = 1'b0;
    #1;
    checks++; if (gnt_a !== 2'b10) $display("FAIL lk_gnt_last: got %b want 10", gnt_a); else passed++;
    step();
    checks++; if (gnt_a !== 2'b01) $display("FAIL lk_handover: got %b want 01", gnt_a); else passed++;
    checks++; if (s_cyc_a !== 1'b1) $display("FAIL lk_no_idle: got %b want 1", s_cyc_a); else passed++;
    checks++; if (s_adr_a !== 32'h4000) $display("FAIL lk_m0_adr: got %h want 4000", s_adr_a); else passed++;
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
  endtask

  task automatic test_pipeline_limit();
    int acc;
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h3000; m0_sel = 4'hF;
    step();
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (s_stb_a === 1'b1 && s_stall === 1'b0) acc++;
      step();
    end
    checks++; if (acc !== 15) $display("FAIL pl_accepted: got %0d want 15", acc); else passed++;
    checks++; if (m0_stall_a !== 1'b1) $display("FAIL pl_stall_full: got %b want 1", m0_stall_a); else passed++;
    checks++; if (s_stb_a !== 1'b0) $display("FAIL pl_stb_full: got %b want 0", s_stb_a); else passed++;
    s_ack = 1'b1;
    #1;
    checks++; if (m0_ack_a !== 1'b1) $display("FAIL pl_first_ack: got %b want 1", m0_ack_a); else passed++;
    step();
    s_ack = 1'b0;
    #1;
    checks++; if (s_stb_a !== 1'b1) $display("FAIL pl_one_more_stb: got %b want 1", s_stb_a); else passed++;
    checks++; if (m0_stall_a !== 1'b0) $display("FAIL pl_one_more_stall: got %b want 0", m0_stall_a); else passed++;
    step();
    checks++; if (s_stb_a !== 1'b0) $display("FAIL pl_refull_stb: got %b want 0", s_stb_a); else passed++;
    checks++; if (m0_stall_a !== 1'b1) $display("FAIL pl_refull_stall: got %b want 1", m0_stall_a); else passed++;
    // release with 15 outstanding, re-grant, then a late ack must be dropped
    m0_cyc = 1'b0; m0_stb = 1'b0;
    step();
    m0_cyc = 1'b1;
    step();
    s_ack = 1'b1;
    #1;
    checks++; if (gnt_a !== 2'b01) $display("FAIL pl_regrant: got %b want 01", gnt_a); else passed++;
    checks++; if (m0_ack_a !== 1'b0) $display("FAIL pl_late_ack: got %b want 0", m0_ack_a); else passed++;
    step();
    s_ack = 1'b0;
    m0_cyc = 1'b0;
    step();
  endtask

  task automatic test_watchdog();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b0; m0_adr = 32'h3000; m0_sel = 4'hF;
    step();
    step();
    m0_stb = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (k < 8) begin
        checks++; if (timeout_b !== 1'b0) $display("FAIL wd_early_to%0d: got %b want 0", k, timeout_b); else passed++;
        checks++; if (m0_err_b !== 1'b0) $display("FAIL wd_early_err%0d: got %b want 0", k, m0_err_b); else passed++;
      end else begin
        checks++; if (timeout_b !== 1'b1) $display("FAIL wd_fire_to: got %b want 1", timeout_b); else passed++;
        checks++; if (m0_err_b !== 1'b1) $display("FAIL wd_fire_err: got %b want 1", m0_err_b); else passed++;
        checks++; if (m1_err_b !== 1'b0) $display("FAIL wd_fire_m1_err: got %b want 0", m1_err_b); else passed++;
        checks++; if (s_cyc_b !== 1'b0) $display("FAIL wd_fire_cyc: got %b want 0", s_cyc_b); else passed++;
        checks++; if (gnt_b !== 2'b00) $display("FAIL wd_fire_gnt: got %b want 00", gnt_b); else passed++;
      end
    end
    step();
    checks++; if (timeout_b !== 1'b0) $display("FAIL wd_pulse_to: got %b want 0", timeout_b); else passed++;
    checks++; if (m0_err_b !== 1'b0) $display("FAIL wd_pulse_err: got %b want 0", m0_err_b); else passed++;
    checks++; if (gnt_b !== 2'b01) $display("FAIL wd_regrant: got %b want 01", gnt_b); else passed++;
    m0_cyc = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    m0_cyc = 1'b1; m0_stb = 1'b1; m0_we = 1'b1; m0_adr = 32'h3000;
    m0_sel = 4'hF; m0_dat = 32'hCAFE_F00D;
    step();
    step();
    step();
    step();
    m0_stb = 1'b0;
    s_ack = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (gnt_a !== 2'b00) $display("FAIL mr_gnt: got %b want 00", gnt_a); else passed++;
    checks++; if (s_cyc_a !== 1'b0) $display("FAIL mr_cyc: got %b want 0", s_cyc_a); else passed++;
    checks++; if (s_we_a !== 1'b0) $display("FAIL mr_we: got %b want 0", s_we_a); else passed++;
    checks++; if (s_dat_a !== 32'h0) $display("FAIL mr_dat: got %h want 0", s_dat_a); else passed++;
    checks++; if (s_sel_a !== 4'h0) $display("FAIL mr_sel: got %h want 0", s_sel_a); else passed++;
    checks++; if (m0_stall_a !== 1'b1) $display("FAIL mr_stall: got %b want 1", m0_stall_a); else passed++;
    checks++; if (m0_ack_a !== 1'b0) $display("FAIL mr_ack: got %b want 0", m0_ack_a); else passed++;
    step();
    s_ack = 1'b0;
    rst = 1'b0;
    step();
    checks++; if (gnt_a !== 2'b01) $display("FAIL mr_regrant: got %b want 01", gnt_a); else passed++;
    for (int i = 0; i < 3; i++) begin
      s_ack = 1'b1;
      #1;
      checks++; if (m0_ack_a !== 1'b0) $display("FAIL mr_late_ack%0d: got %b want 0", i, m0_ack_a); else passed++;
      step();
    end
    s_ack = 1'b0;
    m0_cyc = 1'b0;
    step();
  endtask

  initial begin
    clear_inputs();
    step();
    test_reset();
    test_single_write();
    test_contention();
    test_lock_handover();
    test_pipeline_limit();
    test_watchdog();
    test_reset_mid_burst();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
